// File: rtl/divider_pkg.sv
// divider_pkg: shared MIPS execute-stage definitions used by the iterative
// divider and the instruction decoder.
//   - divider FSM state encoding (IDLE / CALC / FIX)
//   - DIV / DIVU select constants driven on the divider's sign input
package divider_pkg;

   localparam logic [1:0] DIV_ST_IDLE = 2'd0;
   localparam logic [1:0] DIV_ST_CALC = 2'd1;
   localparam logic [1:0] DIV_ST_FIX  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = DIV_ST_IDLE,
      ST_CALC = DIV_ST_CALC,
      ST_FIX  = DIV_ST_FIX
   } div_state_t;

   // Value the decoder places on the divider's sign input.
   localparam logic SEL_DIVU = 1'b0;
   localparam logic SEL_DIV  = 1'b1;

endpackage

// File: rtl/divider_div_step.sv
// div_step: one combinational restoring-division step.
// Ports:
//   rem_in  [WITHD:0]   partial remainder before the step
//   bit_in              next dividend bit (MSB first)
//   divisor [WITHD-1:0] divisor magnitude
//   rem_out [WITHD:0]   partial remainder after the step
//   q_bit               quotient bit produced by the step
module div_step #(
   parameter int WITHD = 32
) (
   input  logic [WITHD:0]   rem_in,
   input  logic             bit_in,
   input  logic [WITHD-1:0] divisor,
   output logic [WITHD:0]   rem_out,
   output logic             q_bit
);

   logic [WITHD:0] shifted_s;
   logic [WITHD:0] trial_s;

   // Shift in the dividend bit, trial-subtract, keep or restore.
   always_comb begin
      shifted_s = (rem_in << 1) | {{WITHD{1'b0}}, bit_in};
      trial_s   = shifted_s - {1'b0, divisor};
      rem_out   = shifted_s;
      q_bit     = 1'b0;
      // The incoming remainder is always below the divisor, so the shifted
      // value fits in WITHD+1 bits and the trial MSB is a true sign bit.
      if (trial_s[WITHD] == 1'b0) begin
         rem_out = trial_s;
         q_bit   = 1'b1;
      end else begin
         rem_out = shifted_s;
         q_bit   = 1'b0;
      end
   end

endmodule

// File: rtl/divider.sv
// divider: multi-cycle iterative integer divider for DIV / DIVU.
// One restoring step per clock on operand magnitudes, then a fix-up cycle
// that applies result signs. Fixed latency WITHD+2 cycles from start to done.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a division (ignored while busy)
//   sign                1 = DIV (signed), 0 = DIVU
//   a, b                dividend, divisor (captured with start)
//   busy                division in progress
//   done                one-cycle pulse, results valid
//   quot, rem           quotient (LO) and remainder (HI)
//   div_zero            last completed division had b == 0
module divider
   import divider_pkg::*;
#(
   parameter int WITHD = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sign,
   input  logic [WITHD-1:0] a,
   input  logic [WITHD-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WITHD-1:0] quot,
   output logic [WITHD-1:0] rem,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(WITHD);

   // Two's-complement negate when en is set.
   function automatic logic [WITHD-1:0] cond_neg(input logic [WITHD-1:0] x,
                                                 input logic en);
      if (en) cond_neg = ~x + WITHD'(1);
      else    cond_neg = x;
   endfunction

   div_state_t       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WITHD-1:0] dvd_r;      // dividend shifts out MSB-first, quotient shifts in
   logic [WITHD-1:0] dvs_r;
   logic [WITHD:0]   prem_r;
   logic [WITHD-1:0] a_raw_r;
   logic             q_neg_r;
   logic             r_neg_r;
   logic             zero_r;
   logic             done_r;
   logic             div_zero_r;
   logic [WITHD-1:0] quot_r;
   logic [WITHD-1:0] rem_r;

   logic             signed_op_s;
   logic [WITHD-1:0] a_mag_s;
   logic [WITHD-1:0] b_mag_s;
   logic [WITHD:0]   step_rem_s;
   logic             step_q_s;

   div_step #(.WITHD(WITHD)) u_step (
      .rem_in  (prem_r),
      .bit_in  (dvd_r[WITHD-1]),
      .divisor (dvs_r),
      .rem_out (step_rem_s),
      .q_bit   (step_q_s)
   );

   // Operand magnitudes; 0x80..0 negates to itself, which is the correct
   // unsigned magnitude.
   always_comb begin
      signed_op_s = (sign == SEL_DIV);
      a_mag_s     = cond_neg(a, signed_op_s & a[WITHD-1]);
      b_mag_s     = cond_neg(b, signed_op_s & b[WITHD-1]);
   end

   // FSM, operand/quotient shift registers, counter and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {CNT_W{1'b0}};
         dvd_r      <= {WITHD{1'b0}};
         dvs_r      <= {WITHD{1'b0}};
         prem_r     <= {(WITHD+1){1'b0}};
         a_raw_r    <= {WITHD{1'b0}};
         q_neg_r    <= 1'b0;
         r_neg_r    <= 1'b0;
         zero_r     <= 1'b0;
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
         quot_r     <= {WITHD{1'b0}};
         rem_r      <= {WITHD{1'b0}};
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  dvd_r   <= a_mag_s;
                  dvs_r   <= b_mag_s;
                  a_raw_r <= a;
                  q_neg_r <= signed_op_s & (a[WITHD-1] ^ b[WITHD-1]);
                  r_neg_r <= signed_op_s & a[WITHD-1];
                  zero_r  <= (b == {WITHD{1'b0}});
                  prem_r  <= {(WITHD+1){1'b0}};
                  cnt_r   <= {CNT_W{1'b0}};
                  state_r <= ST_CALC;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_CALC: begin
               prem_r <= step_rem_s;
               dvd_r  <= {dvd_r[WITHD-2:0], step_q_s};
               cnt_r  <= cnt_r + CNT_W'(1);
               if (cnt_r == CNT_W'(WITHD-1)) begin
                  state_r <= ST_FIX;
               end else begin
                  state_r <= ST_CALC;
               end
            end
            ST_FIX: begin
               // Divide by zero overrides sign handling entirely.
               if (zero_r) begin
                  quot_r <= {WITHD{1'b1}};
                  rem_r  <= a_raw_r;
               end else begin
                  quot_r <= cond_neg(dvd_r, q_neg_r);
                  rem_r  <= cond_neg(prem_r[WITHD-1:0], r_neg_r);
               end
               div_zero_r <= zero_r;
               done_r     <= 1'b1;
               state_r    <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy     = (state_r != ST_IDLE);
   assign done     = done_r;
   assign quot     = quot_r;
   assign rem      = rem_r;
   assign div_zero = div_zero_r;

endmodule

// File: tb/tb_divider.sv
// tb_divider: scoreboard bench for the iterative divider. Stimulus pushes the
// expected result and the edge count at which done must appear; a monitor pops
// and compares on every done pulse.
module tb_divider;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        sign;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] quot;
   logic [31:0] rem;
   logic        div_zero;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      int          exp_edge;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   edge_cnt = 0;

   divider #(.WITHD(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .sign     (sign),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .quot     (quot),
      .rem      (rem),
      .div_zero (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt = edge_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_edge", edge_cnt, e.exp_edge);
            chk("quot", quot, e.q);
            chk("rem", rem, e.r);
            chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
         end
      end
   end

   // Drive a start at the current negedge; the next posedge is edge 0 and
   // done is due at the negedge after edge 33. Returns one negedge later.
   task automatic go(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                     input bit expect_it, input logic [31:0] eq, input logic [31:0] er,
                     input logic edz);
      exp_t e;
      start = 1'b1;
      sign  = ts;
      a     = ta;
      b     = tb_;
      if (expect_it) begin
         e.q = eq; e.r = er; e.dz = edz; e.exp_edge = edge_cnt + 34;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         chk("drain_timeout", sb.size(), 32'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) break;
      end
      if (!done) chk("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; sign = 1'b0; a = 32'd0; b = 32'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_quot", quot, 32'd0);
      chk("rst_rem", rem, 32'd0);
      chk("rst_dz", {31'd0, div_zero}, 32'd0);

      // DIVU 100/7 with busy profile over cycles 1..33 and done in 34.
      go(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2, 1'b0);
      for (int k = 1; k <= 33; k++) begin
         chk("busy_run", {31'd0, busy}, 32'd1);
         chk("done_early", {31'd0, done}, 32'd0);
         @(negedge clk);
      end
      chk("busy_done_cycle", {31'd0, busy}, 32'd0);
      chk("done_cycle34", {31'd0, done}, 32'd1);
      drain();

      // Signed cases.
      go(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      drain();
      go(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
      drain();
      go(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
      drain();
      // Same bits unsigned: 0x80000000 / 0xFFFFFFFF.
      go(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 32'h8000_0000, 1'b0);
      drain();
      go(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1, 32'h0FFF_FFFF, 32'hF, 1'b0);
      drain();

      // Divide by zero, then a normal DIVU clears div_zero.
      go(32'd5, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1);
      drain();
      go(32'd9, 32'd3, 1'b0, 1'b1, 32'd3, 32'd0, 1'b0);
      drain();

      // Start while busy is ignored.
      go(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2, 1'b0);
      repeat (8) @(negedge clk);
      go(32'd50, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      // Back-to-back: start in the done cycle is accepted.
      wait_done();
      go(32'd50, 32'd5, 1'b0, 1'b1, 32'd10, 32'd0, 1'b0);
      drain();

      // Reset mid-operation aborts with no done.
      go(32'd77, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_quot", quot, 32'd0);
      chk("abort_rem", rem, 32'd0);
      chk("abort_dz", {31'd0, div_zero}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("abort_no_done_quot", quot, 32'd0);
      go(32'd1000, 32'd10, 1'b0, 1'b1, 32'd100, 32'd0, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/divider.md
# divider

Multi-cycle iterative integer divider for the MIPS32 datapath, executing DIV (signed) and DIVU (unsigned) by repeated trial subtraction, one quotient bit per clock. It is the subtract-and-shift counterpart of the combinational adder. It sits beside the ALU in the execute stage. The pipeline controller starts it and stalls on `busy`, then writes `quot` to LO and `rem` to HI when `done` pulses.

## Interface
- `WITHD`, 32, operand/result width in bits (≥2)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a division; sampled only when not busy
- `sign`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start`
- `a`  in  WITHD  dividend; sampled with `start`
- `b`  in  WITHD  divisor; sampled with `start`
- `busy`  out  1  division in progress; new `start` ignored
- `done`  out  1  one-cycle pulse: `quot`/`rem`/`div_zero` valid
- `quot`  out  WITHD  quotient (to LO)
- `rem`  out  WITHD  remainder (to HI)
- `div_zero`  out  1  last division had `b == 0`

## Operation
- States: IDLE, CALC, FIX.
- IDLE: if `start`, latch operands and go to CALC.
  - Latched values: |a|, |b| (magnitudes when `sign`=1, raw otherwise), sign of quotient = a[msb]^b[msb], sign of remainder = a[msb], zero flag = (b == 0).
  - Clear the partial remainder and the bit counter.
- CALC: one restoring step per cycle for exactly WITHD cycles.
  - Partial remainder is WITHD+1 bits wide.
  - Each step: shift remainder left, shifting in the next dividend MSB.
  - Trial-subtract |b|. If the result is non-negative, keep it and the quotient bit is 1; otherwise restore and the quotient bit is 0.
  - When the counter reaches WITHD-1, go to FIX.
- FIX: one cycle. Apply signs and register the outputs, then return to IDLE with `done`=1 for one cycle.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed overflow: 0x80000000 / -1 gives `quot`=0x80000000 (two's-complement wrap) and `rem`=0. There is no flag.
  - Divide by zero overrides signs: `quot`={WITHD{1}}, `rem`=raw `a`, `div_zero`=1. Latency is unchanged.
- Results hold until the next FIX. `div_zero` updates only in FIX.
- `start` while busy is ignored and its operands are not captured.

## Timing
- Reset (async assert, sync release): state IDLE; `busy`, `done`, `div_zero`=0; `quot`=`rem`=0.
- Cycle count, with `start` accepted at edge 0:
  - Edges 1..WITHD: CALC.
  - Edge WITHD+1: FIX.
  - `done`=1 in cycle WITHD+2, i.e. cycle 34 for WITHD=32.
- Fixed latency of WITHD+2 cycles from `start` to `done`, for every operand value including `b`=0.
- `busy`=1 from cycle 1 through cycle WITHD+1. It is 0 in the `done` cycle.
- Back-to-back: `start` asserted in the `done` cycle is accepted. The next `done` follows WITHD+2 cycles later.
- Reset asserted mid-CALC or mid-FIX aborts immediately: all outputs return to reset values and no `done` pulses.
- `done` is registered with no combinational path from any input. `busy` is decoded from state only.

## Structure
- The shared MIPS package/header holds:
  - the divider state encoding (IDLE/CALC/FIX localparams);
  - DIV/DIVU select constants shared with the decoder.
- One natural sub-module, `div_step`: a combinational single restoring step.
  - Inputs: remainder (WITHD+1), incoming dividend bit, |b|.
  - Outputs: next remainder and quotient bit.
- The top level contains the FSM, counter (clog2(WITHD) bits), operand/quotient shift registers, and sign fix-up.

## Test plan
- DIVU: a=100, b=7, start at cycle 0 -> `done` in cycle 34 with `quot`=14, `rem`=2, `div_zero`=0; `busy` high in cycles 1..33.
- DIV: a=-7 (0xFFFFFFF9), b=2 -> `quot`=0xFFFFFFFD (-3), `rem`=0xFFFFFFFF (-1). Also a=7, b=-2 -> `quot`=-3, `rem`=1.
- DIV overflow: a=0x80000000, b=0xFFFFFFFF -> `quot`=0x80000000, `rem`=0.
- Divide by zero, DIV: a=5, b=0 -> `done` at cycle 34, `quot`=0xFFFFFFFF, `rem`=5, `div_zero`=1. Next DIVU 9/3 -> `quot`=3, `rem`=0, `div_zero`=0.
- Handshake:
  - `start` with 50/5 at cycle 10 during a 100/7 run is ignored; results are 14/2.
  - `start` in the `done` cycle with 50/5 is accepted -> `quot`=10, `rem`=0, exactly 34 cycles later.
- Reset: assert `rst_n`=0 at cycle 12 of an operation -> all outputs 0 immediately, no `done`. After release, 1000/10 yields `quot`=100, `rem`=0.
